// File: rtl/ecall_unit_pkg.sv
// Shared constants and state encoding for the ecall service unit.
// Error codes are kept as 8-bit two's complement and sign-extended at use.
package ecall_unit_pkg;

   localparam int ECALL_STATE_BITS = 3;

   localparam int SYS_WRITE = 64;
   localparam int SYS_EXIT  = 93;

   localparam logic [7:0] ERR_EBADF  = 8'hF7;  // -9
   localparam logic [7:0] ERR_ENOSYS = 8'hDA;  // -38

   typedef enum logic [ECALL_STATE_BITS-1:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_SEND    = 3'd3,
      S_DONE    = 3'd4,
      S_HALT    = 3'd5
   } ecall_state_e;

endpackage

// File: rtl/ecall_unit.sv
// Services ecall write/exit for the single-cycle core, stalling the PC while busy.
// tx handshake: a byte moves on a cycle with tx_valid=1 and tx_ready=1; until then tx_valid and tx_data hold.
module ecall_unit
   import ecall_unit_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ecall,
   input  logic [XLEN-1:0] a0,
   input  logic [XLEN-1:0] a1,
   input  logic [XLEN-1:0] a2,
   input  logic [XLEN-1:0] a7,
   output logic            stall,
   output logic            halted,
   output logic [7:0]      exit_code,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic [7:0]      mem_rdata,
   output logic            tx_valid,
   output logic [7:0]      tx_data,
   input  logic            tx_ready,
   output logic            wb_en,
   output logic [XLEN-1:0] wb_data,
   output logic [ECALL_STATE_BITS-1:0] fsm_state
);

   ecall_state_e    state;
   logic [XLEN-1:0] ptr;
   logic [XLEN-1:0] cnt;
   logic [XLEN-1:0] total;
   logic            fd_ok;

   function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
      return {{(XLEN-8){v[7]}}, v};
   endfunction

   assign fd_ok     = (a0 == XLEN'(1)) || (a0 == XLEN'(2));
   assign fsm_state = state;

   // Combinational so the PC is frozen in the very cycle an ecall is decoded.
   assign stall = ((state == S_IDLE) && ecall) ||
                  (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                  (state == S_SEND)   || (state == S_HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         total     <= '0;
         halted    <= 1'b0;
         exit_code <= 8'h00;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         wb_en     <= 1'b0;
         wb_data   <= '0;
      end else begin
         mem_req <= 1'b0;
         wb_en   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ecall) begin
                  if (a7 == XLEN'(SYS_EXIT)) begin
                     state     <= S_HALT;
                     halted    <= 1'b1;
                     exit_code <= a0[7:0];
                  end else if (a7 == XLEN'(SYS_WRITE)) begin
                     if (a2 == '0) begin
                        state   <= S_DONE;
                        wb_en   <= 1'b1;
                        wb_data <= '0;
                     end else if (fd_ok) begin
                        ptr      <= a1;
                        cnt      <= a2;
                        total    <= a2;
                        state    <= S_RD_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= a1;
                     end else begin
                        state   <= S_DONE;
                        wb_en   <= 1'b1;
                        wb_data <= sext8(ERR_EBADF);
                     end
                  end else begin
                     state   <= S_DONE;
                     wb_en   <= 1'b1;
                     wb_data <= sext8(ERR_ENOSYS);
                  end
               end
            end
            S_RD_REQ: state <= S_RD_WAIT;
            S_RD_WAIT: begin
               tx_data  <= mem_rdata;
               tx_valid <= 1'b1;
               state    <= S_SEND;
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  ptr      <= ptr + XLEN'(1);
                  cnt      <= cnt - XLEN'(1);
                  if (cnt == XLEN'(1)) begin
                     state   <= S_DONE;
                     wb_en   <= 1'b1;
                     wb_data <= total;
                  end else begin
                     state    <= S_RD_REQ;
                     mem_req  <= 1'b1;
                     mem_addr <= ptr + XLEN'(1);
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ecall_unit.sv
// Directed bench for ecall_unit: exit, writes with and without backpressure,
// error returns, address wrap and reset in the middle of a transfer.
module tb_ecall_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ecall;
   logic [63:0] a0, a1, a2, a7;
   logic        stall, halted;
   logic [7:0]  exit_code;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        wb_en;
   logic [63:0] wb_data;
   logic [2:0]  fsm_state;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  exp_q[$];
   logic [63:0] addr_q[$];
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [7:0]  prev_data  = 8'h00;

   ecall_unit #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .ecall(ecall),
      .a0(a0), .a1(a1), .a2(a2), .a7(a7),
      .stall(stall), .halted(halted), .exit_code(exit_code),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .wb_en(wb_en), .wb_data(wb_data), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory: "abc" at 0x100, elsewhere low address byte XOR 0x3C.
   function automatic logic [7:0] byte_at(input logic [63:0] addr);
      case (addr)
         64'h100: return 8'h61;
         64'h101: return 8'h62;
         64'h102: return 8'h63;
         default: return addr[7:0] ^ 8'h3C;
      endcase
   endfunction

   always @(posedge clk) mem_rdata <= mem_req ? byte_at(mem_addr) : 8'h00;

   // scoreboard on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         prev_valid <= 1'b0;
      end else begin
         if (mem_req) begin
            if (addr_q.size() == 0) check("mem_req_unexpected", 64'(mem_addr), 64'hDEAD);
            else check("mem_addr", mem_addr, addr_q.pop_front());
         end
         if (prev_valid && !prev_ready)
            check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("tx_unexpected", 64'(tx_data), 64'hBEEF);
            else check("tx_data", 64'(tx_data), 64'(exp_q.pop_front()));
         end
         prev_valid <= tx_valid;
         prev_ready <= tx_ready;
         prev_data  <= tx_data;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_stall"},    64'(stall), 64'd0);
      check({tag, "_halted"},   64'(halted), 64'd0);
      check({tag, "_exitcode"}, 64'(exit_code), 64'd0);
      check({tag, "_memreq"},   {63'd0, mem_req} | mem_addr, 64'd0);
      check({tag, "_tx"},       {55'd0, tx_valid, tx_data}, 64'd0);
      check({tag, "_wb"},       {63'd0, wb_en} | wb_data, 64'd0);
   endtask

   // driver: issue one ecall and run it to the DONE cycle
   task automatic run_call(input string tag, input logic [63:0] num, input logic [63:0] fd,
                           input logic [63:0] buf_addr, input logic [63:0] len,
                           input int bp_start, input int bp_len,
                           input logic [63:0] exp_ret, input int exp_cycles);
      int cyc = 0;
      a7 = num; a0 = fd; a1 = buf_addr; a2 = len;
      ecall = 1'b1;
      tx_ready = 1'b1;
      #1;
      check({tag, "_stall_decode"}, 64'(stall), 64'd1);
      while (!wb_en && cyc < 300) begin
         tick();
         cyc++;
         tx_ready = !(cyc >= bp_start && cyc < bp_start + bp_len);
      end
      if (!wb_en) check({tag, "_timeout"}, 64'(cyc), 64'(exp_cycles));
      check({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
      check({tag, "_ret"}, wb_data, exp_ret);
      check({tag, "_stall_done"}, 64'(stall), 64'd0);
      ecall = 1'b0;
      tick();
      check({tag, "_wb_pulse"}, 64'(wb_en), 64'd0);
      check({tag, "_drained"}, 64'(exp_q.size() + addr_q.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b1; ecall = 1'b0; tx_ready = 1'b1;
      a0 = '0; a1 = '0; a2 = '0; a7 = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_reset_values("reset");

      // exit
      a7 = 64'd93; a0 = 64'h2A; ecall = 1'b1;
      #1;
      check("exit_stall_decode", 64'(stall), 64'd1);
      tick();
      check("exit_halted", 64'(halted), 64'd1);
      check("exit_code", 64'(exit_code), 64'h2A);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("exit_stall_hold", {62'd0, stall, halted}, 64'd3);
      end
      reset = 1'b1; ecall = 1'b0;
      tick();
      reset = 1'b0;
      check_reset_values("exit_reset");

      // write 3 bytes, no backpressure: DONE on cycle 10
      exp_q = '{8'h61, 8'h62, 8'h63};
      addr_q = '{64'h100, 64'h101, 64'h102};
      run_call("write3", 64'd64, 64'd1, 64'h100, 64'd3, 0, 0, 64'd3, 10);

      // same on fd 2, tx_ready low 5 cycles while byte 2 is offered (cycle 6)
      exp_q = '{8'h61, 8'h62, 8'h63};
      addr_q = '{64'h100, 64'h101, 64'h102};
      run_call("bp", 64'd64, 64'd2, 64'h100, 64'd3, 6, 5, 64'd3, 15);

      run_call("ebadf", 64'd64, 64'd5, 64'h100, 64'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFF7, 1);
      run_call("enosys", 64'd17, 64'd1, 64'h100, 64'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFDA, 1);
      run_call("zero_len", 64'd64, 64'd1, 64'h100, 64'd0, 0, 0, 64'd0, 1);

      // address wrap: bytes 0xFF^0x3C and 0x00^0x3C
      exp_q = '{8'hC3, 8'h3C};
      addr_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      run_call("wrap", 64'd64, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 64'd2, 7);

      // reset while a byte is being offered
      addr_q = '{64'h100};
      a7 = 64'd64; a0 = 64'd1; a1 = 64'h100; a2 = 64'd2;
      tx_ready = 1'b0; ecall = 1'b1;
      tick(); tick(); tick();
      check("rst_send_valid", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'h61});
      reset = 1'b1; ecall = 1'b0;
      tick();
      reset = 1'b0;
      check_reset_values("rst_send");
      exp_q.delete();
      addr_q.delete();
      exp_q = '{8'h61, 8'h62, 8'h63};
      addr_q = '{64'h100, 64'h101, 64'h102};
      run_call("after_rst", 64'd64, 64'd1, 64'h100, 64'd3, 0, 0, 64'd3, 10);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ecall_unit.md
# ecall_unit

Services the `ecall` request raised by the instruction decoder in the single-cycle core. While a call is in progress it stalls the core by holding the PC on the `ecall` instruction. It implements two calls:
- `write` (a7=64): streams bytes from data memory to a byte-wide console sink.
- `exit` (a7=93): halts the core.

On completion it writes a return value to a0 and releases the stall so the core retires the `ecall`.

## Interface
- `XLEN`, 64, register and address width.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `ecall` in 1: decoder flag; high while the current instruction is `ecall`.
- `a0`, `a1`, `a2`, `a7` in XLEN: register-file read values (fd, buffer address, length, call number).
- `stall` out 1: holds PC and blocks register/memory writes of the core.
- `halted` out 1: sticky; core has executed `exit`.
- `exit_code` out 8: `a0[7:0]` captured at `exit`.
- `mem_req` out 1, `mem_addr` out XLEN: byte read request to data memory.
- `mem_rdata` in 8: read byte, valid the cycle after `mem_req`.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: console byte stream.
- `wb_en` out 1, `wb_data` out XLEN: one-cycle write of the return value to a0.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, SEND, DONE, HALT.
- **IDLE**, `ecall`=1: decode `a7`.
  - 93 → HALT; capture `exit_code`.
  - 64 with `a0` ∈ {1,2} and `a2`≠0 → capture ptr=`a1`, cnt=`a2`, total=`a2`; go RD_REQ.
  - 64 with `a2`=0 → DONE, ret=0.
  - 64 with other fd → DONE, ret=−9 (EBADF).
  - Any other `a7` → DONE, ret=−38 (ENOSYS).
- **RD_REQ**: `mem_req`=1, `mem_addr`=ptr → RD_WAIT.
- **RD_WAIT**: latch `mem_rdata` into `tx_data` → SEND.
- **SEND**: `tx_valid`=1. On `tx_ready`=1: ptr+=1, cnt−=1; if cnt becomes 0 → DONE with ret=total, else RD_REQ.
- **DONE**: `wb_en`=1, `wb_data`=ret, `stall`=0 → IDLE unconditionally. The PC advances this cycle, so the held `ecall` is not re-entered.
- **HALT**: absorbing until `reset`; `halted`=1, `stall`=1.
- `stall` = (IDLE & `ecall`) | state ∈ {RD_REQ, RD_WAIT, SEND, HALT}. It is combinational so the PC never advances past an unserviced `ecall`.
- Arithmetic:
  - ptr wraps modulo 2^XLEN.
  - cnt is XLEN wide.
  - ret is sign-extended to XLEN.
  - The full 64-bit `a2` is honoured (no truncation).
- Handshake: once `tx_valid` rises, `tx_data` is stable and `tx_valid` stays high until a cycle with `tx_ready`=1. `tx_ready` has no combinational effect on outputs other than state advance.

## Timing
- Reset values:
  - state=IDLE.
  - `stall`=0 when `ecall`=0.
  - `halted`=0, `exit_code`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `tx_valid`=0, `tx_data`=0.
  - `wb_en`=0, `wb_data`=0.
- Per-byte latency: 3 cycles (RD_REQ, RD_WAIT, SEND) with `tx_ready` held high. A `write` of N bytes occupies 1+3N cycles from `ecall` to the DONE cycle inclusive.
- Zero-length, bad-fd and unknown calls: `stall` high in the IDLE decode cycle, DONE the next cycle.
- `reset` mid-transfer: next cycle IDLE. `tx_valid` drops without a handshake (reset overrides protocol) and the partial count is discarded.
- `reset` in HALT clears `halted`.

## Structure
- Add to `diagv2_const.vh`:
  - `SYS_WRITE`=64, `SYS_EXIT`=93.
  - `ERR_EBADF`=−9, `ERR_ENOSYS`=−38.
  - State encoding macros, `EcallStateBits`=3.
- No sub-module; one FSM with ptr/cnt/total registers.
- Top level muxes `wb_en`/`wb_data` onto the a0 write port and ANDs `~stall` into `regWrite`/`memWrite`.

## Test plan
- **exit:** `ecall`, a7=93, a0=0x2A → next cycle `halted`=1, `exit_code`=0x2A, `stall` stays 1 for 20 cycles; `reset` clears all.
- **write 3 bytes:** a7=64, a0=1, a1=0x100, a2=3, memory "abc", `tx_ready`=1 → `tx_data` 0x61, 0x62, 0x63 on cycles 3, 6, 9; DONE at cycle 10 with `wb_data`=3.
- **Backpressure:** same call with `tx_ready` low for 5 cycles during byte 2 → `tx_valid`/`tx_data`=0x62 held stable; totals unchanged, DONE delayed by 5 cycles.
- **Error returns:**
  - a7=64, a0=5 → one-cycle `wb_data`=0xFFFF_FFFF_FFFF_FFF7.
  - a7=17 → `wb_data`=0xFFFF_FFFF_FFFF_FFDA; no `mem_req`.
- **Edge cases:**
  - a2=0 → `wb_data`=0, no `tx_valid`.
  - a1=0xFFFF_FFFF_FFFF_FFFF, a2=2 → `mem_addr` sequence …FFFF then 0x0.
- **Reset mid-SEND:** `reset` pulsed while `tx_valid`=1 → next cycle all outputs at reset values; a subsequent write completes normally.
